// File: rtl/pipeline_pkg.sv
// Shared widths and branch funct3 encodings for the 5-stage core pipeline registers.
package pipeline_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_unit.sv
// Decodes a conditional-branch funct3 against the ALU ZERO/GEQ flags.
import pipeline_pkg::*;

module branch_cond_unit (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       geq_i,
  output logic       cond_o
);

  // Unsupported encodings (signed compares, reserved) resolve as not taken.
  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = zero_i;
      F3_BNE:  cond_o = ~zero_i;
      F3_BLTU: cond_o = ~geq_i;
      F3_BGEU: cond_o = geq_i;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_pipeline_reg.sv
// EX/MEM pipeline register: captures ALU results and MEM/WB control, resolves
// conditional branches, squashes the wrong-path instruction and counts taken branches.
import pipeline_pkg::*;

module ex_mem_pipeline_reg #(
  parameter int DATA_W     = pipeline_pkg::DATA_W,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int CNT_W      = pipeline_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic                  ex_zero,
  input  logic                  ex_geq,
  input  logic [DATA_W-1:0]     ex_rs2_data,
  input  logic [DATA_W-1:0]     ex_branch_target,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_branch,
  input  logic [2:0]            ex_funct3,
  output logic                  mem_valid,
  output logic [DATA_W-1:0]     mem_alu_result,
  output logic [DATA_W-1:0]     mem_rs2_data,
  output logic [DATA_W-1:0]     mem_branch_target,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic                  mem_branch_taken,
  output logic                  branch_flush,
  output logic [CNT_W-1:0]      taken_count
);

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     alu_result_q;
  logic [DATA_W-1:0]     rs2_data_q;
  logic [DATA_W-1:0]     branch_target_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  taken_q, taken_d;
  logic [CNT_W-1:0]      count_q;
  logic                  cond;
  logic                  load_en;

  branch_cond_unit u_branch_cond (
    .funct3_i (ex_funct3),
    .zero_i   (ex_zero),
    .geq_i    (ex_geq),
    .cond_o   (cond)
  );

  // A taken branch already in MEM means the instruction now in EX is wrong-path.
  always_comb begin
    valid_d      = ex_valid & ~taken_q;
    reg_write_d  = ex_reg_write  & valid_d;
    mem_read_d   = ex_mem_read   & valid_d;
    mem_write_d  = ex_mem_write  & valid_d;
    mem_to_reg_d = ex_mem_to_reg & valid_d;
    taken_d      = ex_branch & cond & valid_d;
  end

  assign load_en = ~flush & ~stall;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q         <= 1'b0;
      alu_result_q    <= '0;
      rs2_data_q      <= '0;
      branch_target_q <= '0;
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      taken_q         <= 1'b0;
    end else if (!stall) begin
      valid_q         <= valid_d;
      alu_result_q    <= ex_alu_result;
      rs2_data_q      <= ex_rs2_data;
      branch_target_q <= ex_branch_target;
      rd_q            <= ex_rd;
      reg_write_q     <= reg_write_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      taken_q         <= taken_d;
    end
  end

  // Flush does not clear the counter; only reset does.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_en && taken_d) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign mem_valid         = valid_q;
  assign mem_alu_result    = alu_result_q;
  assign mem_rs2_data      = rs2_data_q;
  assign mem_branch_target = branch_target_q;
  assign mem_rd            = rd_q;
  assign mem_reg_write     = reg_write_q;
  assign mem_mem_read      = mem_read_q;
  assign mem_mem_write     = mem_write_q;
  assign mem_mem_to_reg    = mem_to_reg_q;
  assign mem_branch_taken  = taken_q;
  assign branch_flush      = taken_q;
  assign taken_count       = count_q;

endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// Self-checking bench for ex_mem_pipeline_reg: directed scenarios plus randomized
// traffic against a behavioural model; a CNT_W=4 copy exercises counter wrap.
module tb_ex_mem_pipeline_reg;

  logic        clk;
  logic        reset, stall, flush;
  logic        ex_valid, ex_zero, ex_geq;
  logic [63:0] ex_alu_result, ex_rs2_data, ex_branch_target;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic [2:0]  ex_funct3;

  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic [63:0] mem_alu_result, mem_rs2_data, mem_branch_target;
  logic [4:0]  mem_rd;
  logic        mem_branch_taken, branch_flush;
  logic [31:0] taken_count;

  logic        d4_valid, d4_reg_write, d4_mem_read, d4_mem_write, d4_mem_to_reg;
  logic [63:0] d4_alu_result, d4_rs2_data, d4_branch_target;
  logic [4:0]  d4_rd;
  logic        d4_branch_taken, d4_branch_flush;
  logic [3:0]  d4_taken_count;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  bit          m_valid, m_rw, m_mr, m_mw, m_m2r, m_taken;
  logic [63:0] m_alu, m_rs2, m_tgt;
  logic [4:0]  m_rd;
  longint      m_branches;

  ex_mem_pipeline_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_geq(ex_geq),
    .ex_rs2_data(ex_rs2_data), .ex_branch_target(ex_branch_target), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
    .mem_branch_target(mem_branch_target), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_branch_taken(mem_branch_taken),
    .branch_flush(branch_flush), .taken_count(taken_count)
  );

  ex_mem_pipeline_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_geq(ex_geq),
    .ex_rs2_data(ex_rs2_data), .ex_branch_target(ex_branch_target), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
    .mem_valid(d4_valid), .mem_alu_result(d4_alu_result), .mem_rs2_data(d4_rs2_data),
    .mem_branch_target(d4_branch_target), .mem_rd(d4_rd), .mem_reg_write(d4_reg_write),
    .mem_mem_read(d4_mem_read), .mem_mem_write(d4_mem_write),
    .mem_mem_to_reg(d4_mem_to_reg), .mem_branch_taken(d4_branch_taken),
    .branch_flush(d4_branch_flush), .taken_count(d4_taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit branch_rule(input logic [2:0] f3, input bit z, input bit g);
    return (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd6 && !g) || (f3 == 3'd7 && g);
  endfunction

  // Advances the model by one edge using the inputs currently applied.
  task automatic model_step();
    bit live;
    if (reset) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r, m_taken} = '0;
      m_alu = '0; m_rs2 = '0; m_tgt = '0; m_rd = '0;
      m_branches = 0;
    end else if (flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r, m_taken} = '0;
      m_alu = '0; m_rs2 = '0; m_tgt = '0; m_rd = '0;
    end else if (!stall) begin
      live    = ex_valid && !m_taken;
      m_valid = live;
      m_rw    = live && ex_reg_write;
      m_mr    = live && ex_mem_read;
      m_mw    = live && ex_mem_write;
      m_m2r   = live && ex_mem_to_reg;
      m_taken = live && ex_branch && branch_rule(ex_funct3, ex_zero, ex_geq);
      m_alu = ex_alu_result; m_rs2 = ex_rs2_data; m_tgt = ex_branch_target; m_rd = ex_rd;
      if (m_taken) m_branches++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; ex_valid = 0; ex_zero = 0; ex_geq = 0;
    ex_alu_result = '0; ex_rs2_data = '0; ex_branch_target = '0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_branch = 0; ex_funct3 = '0;
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; flush = 0; ex_valid = 1; ex_zero = 1; ex_geq = 1;
    ex_alu_result = 64'hDEAD; ex_rs2_data = 64'hBEEF; ex_branch_target = 64'h40;
    ex_rd = 5'd7; ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 1; ex_mem_to_reg = 1;
    ex_branch = 1; ex_funct3 = 3'd0;
    tick(); tick();
    n_cmp++;
    if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
         mem_branch_taken, branch_flush} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctl actual=%b required=0", {mem_valid, mem_reg_write,
               mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_branch_taken, branch_flush});
    end
    n_cmp++;
    if ({mem_alu_result, mem_rs2_data, mem_branch_target, mem_rd} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data actual=%h/%h/%h/%h required=0",
               mem_alu_result, mem_rs2_data, mem_branch_target, mem_rd);
    end
    n_cmp++;
    if (taken_count !== 32'd0 || d4_taken_count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_count actual=%0d/%0d required=0", taken_count, d4_taken_count);
    end
    idle_inputs();
  endtask

  task automatic test_pass_through();
    idle_inputs();
    ex_valid = 1; ex_alu_result = 64'h1234; ex_rd = 5'd5; ex_reg_write = 1;
    tick();
    n_cmp++;
    if (mem_alu_result !== 64'h1234 || mem_rd !== 5'd5 || mem_reg_write !== 1'b1 ||
        mem_valid !== 1'b1 || mem_branch_taken !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pass_through actual alu=%h rd=%0d rw=%b v=%b bt=%b required alu=1234 rd=5 rw=1 v=1 bt=0",
               mem_alu_result, mem_rd, mem_reg_write, mem_valid, mem_branch_taken);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_branch();
    idle_inputs();
    ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b000; ex_zero = 1; ex_branch_target = 64'h100;
    tick();
    n_cmp++;
    if (mem_branch_taken !== 1'b1 || branch_flush !== 1'b1 || taken_count !== 32'd1 ||
        mem_branch_target !== 64'h100) begin
      n_fail++;
      $display("[TB] FAIL branch_taken actual bt=%b bf=%b cnt=%0d tgt=%h required 1 1 1 100",
               mem_branch_taken, branch_flush, taken_count, mem_branch_target);
    end
    idle_inputs();
    ex_valid = 1; ex_reg_write = 1; ex_alu_result = 64'h77;
    tick();
    n_cmp++;
    if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0 || mem_branch_taken !== 1'b0 ||
        mem_alu_result !== 64'h77 || taken_count !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL self_squash actual v=%b rw=%b bt=%b alu=%h cnt=%0d required 0 0 0 77 1",
               mem_valid, mem_reg_write, mem_branch_taken, mem_alu_result, taken_count);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_conditions();
    logic [2:0] codes [4] = '{3'b001, 3'b110, 3'b111, 3'b010};
    bit exp_t;
    foreach (codes[i]) begin
      for (int c = 0; c < 4; c++) begin
        idle_inputs();
        tick();
        ex_valid = 1; ex_branch = 1; ex_funct3 = codes[i];
        ex_zero = c[0]; ex_geq = c[1];
        exp_t = (codes[i] == 3'b001) ? !c[0] : (codes[i] == 3'b110) ? !c[1] :
                (codes[i] == 3'b111) ? c[1] : 1'b0;
        tick();
        n_cmp++;
        if (mem_branch_taken !== exp_t || mem_branch_taken !== m_taken ||
            taken_count !== m_branches[31:0]) begin
          n_fail++;
          $display("[TB] FAIL cond f3=%b z=%b g=%b actual bt=%b cnt=%0d required bt=%b cnt=%0d",
                   codes[i], c[0], c[1], mem_branch_taken, taken_count, exp_t, m_branches);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_flush();
    logic [31:0] cnt_a;
    idle_inputs();
    ex_valid = 1; ex_alu_result = 64'hA0A0; ex_rd = 5'd9; ex_reg_write = 1;
    ex_branch = 1; ex_funct3 = 3'b111; ex_geq = 1; ex_branch_target = 64'h200;
    tick();
    cnt_a = taken_count;
    n_cmp++;
    if (cnt_a !== m_branches[31:0] || mem_branch_taken !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL load_a actual cnt=%0d bt=%b required cnt=%0d bt=1",
               cnt_a, mem_branch_taken, m_branches);
    end
    for (int k = 0; k < 3; k++) begin
      stall = 1; ex_valid = 1; ex_alu_result = {$urandom, $urandom}; ex_rd = 5'($urandom);
      ex_reg_write = 0; ex_branch = 1; ex_funct3 = 3'b000; ex_zero = 1;
      tick();
      n_cmp++;
      if (mem_alu_result !== 64'hA0A0 || mem_rd !== 5'd9 || mem_reg_write !== 1'b1 ||
          branch_flush !== 1'b1 || mem_branch_target !== 64'h200 || taken_count !== cnt_a) begin
        n_fail++;
        $display("[TB] FAIL stall_hold%0d actual alu=%h rd=%0d rw=%b bf=%b cnt=%0d required A0A0 9 1 1 %0d",
                 k, mem_alu_result, mem_rd, mem_reg_write, branch_flush, taken_count, cnt_a);
      end
    end
    stall = 1; flush = 1;
    tick();
    n_cmp++;
    if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
         mem_branch_taken, branch_flush} !== 7'b0 || mem_alu_result !== 64'h0 ||
        taken_count !== cnt_a) begin
      n_fail++;
      $display("[TB] FAIL stall_flush actual v=%b rw=%b bt=%b alu=%h cnt=%0d required 0 0 0 0 %0d",
               mem_valid, mem_reg_write, mem_branch_taken, mem_alu_result, taken_count, cnt_a);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 8);
      stall = ($urandom_range(0, 99) < 15);
      ex_valid = ($urandom_range(0, 9) < 8);
      ex_zero = 1'($urandom); ex_geq = 1'($urandom);
      ex_alu_result = {$urandom, $urandom}; ex_rs2_data = {$urandom, $urandom};
      ex_branch_target = {$urandom, $urandom}; ex_rd = 5'($urandom);
      {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} = 4'($urandom);
      ex_branch = 1'($urandom); ex_funct3 = 3'($urandom);
      tick();
      n_cmp++;
      if ({mem_valid, mem_alu_result, mem_rs2_data, mem_branch_target, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_branch_taken, branch_flush} !==
          {m_valid, m_alu, m_rs2, m_tgt, m_rd, m_rw, m_mr, m_mw, m_m2r, m_taken, m_taken}) begin
        n_fail++;
        $display("[TB] FAIL random%0d actual v=%b alu=%h rs2=%h tgt=%h rd=%0d ctl=%b bt=%b bf=%b required v=%b alu=%h rs2=%h tgt=%h rd=%0d ctl=%b bt=%b",
                 n, mem_valid, mem_alu_result, mem_rs2_data, mem_branch_target, mem_rd,
                 {mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, mem_branch_taken,
                 branch_flush, m_valid, m_alu, m_rs2, m_tgt, m_rd, {m_rw, m_mr, m_mw, m_m2r}, m_taken);
      end
      n_cmp++;
      if (taken_count !== m_branches[31:0] || d4_taken_count !== m_branches[3:0]) begin
        n_fail++;
        $display("[TB] FAIL random_count%0d actual=%0d/%0d required=%0d/%0d", n,
                 taken_count, d4_taken_count, m_branches[31:0], m_branches[3:0]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    for (int b = 1; b <= 17; b++) begin
      ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b000; ex_zero = 1;
      tick();
      ex_valid = 0; ex_branch = 0;
      tick();
      if (b >= 15) begin
        n_cmp++;
        if (d4_taken_count !== 4'(b % 16) || taken_count !== 32'(b)) begin
          n_fail++;
          $display("[TB] FAIL wrap_b%0d actual=%0d/%0d required=%0d/%0d",
                   b, d4_taken_count, taken_count, b % 16, b);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_pass_through();
    test_branch();
    test_conditions();
    test_stall_flush();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
